// File: rtl/lcd_spi_target_rx_pkg.sv
// lcd_spi_pkg: shared defaults, the receiver state type, the FIFO entry
// layout and the helper that picks which synced SCLK edge captures MOSI.
package lcd_spi_pkg;

  localparam int LCD_DATA_W     = 8;
  localparam int LCD_FIFO_DEPTH = 16;
  localparam bit LCD_CPOL       = 1'b0;
  localparam bit LCD_CPHA       = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } rx_state_t;

  // Default-width FIFO entry; the receiver builds the same layout at its
  // own DATA_W.
  typedef struct packed {
    logic                  dc;
    logic                  first;
    logic [LCD_DATA_W-1:0] data;
  } lcd_entry_t;

  // The capture edge is the rising SCLK edge when CPOL and CPHA agree
  // (mode 0: leading edge of an idle-low clock, mode 3: trailing edge of an
  // idle-high clock); otherwise it is the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/lcd_spi_target_rx_fifo.sv
// lcd_rx_fifo: synchronous FIFO with extra-MSB pointers.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. The head word reads as zero while the FIFO is empty.
module lcd_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array; left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Head-of-FIFO view, forced to zero when nothing is stored.
  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem[rd_ptr_reg[AW-1:0]];
  end

endmodule

// File: rtl/lcd_spi_target_rx.sv
// lcd_spi_target_rx: SPI target receiver for the LCD command/data link.
// Oversamples the SPI pins in the clk_clk domain and deserialises MSB-first
// words. Each word is tagged with D/C and a first-of-frame flag and queued
// in lcd_rx_fifo.
// Build option LCD_SPI_9BIT_EN: 3-wire 9-bit mode. The first bit of each
// word is the D/C tag and spi_dc is ignored.
module lcd_spi_target_rx
  import lcd_spi_pkg::*;
#(
  parameter int DATA_W     = LCD_DATA_W,
  parameter int FIFO_DEPTH = LCD_FIFO_DEPTH,
  parameter bit CPOL       = LCD_CPOL,
  parameter bit CPHA       = LCD_CPHA
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  input  logic              spi_dc,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_dc,
  output logic              rx_first,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              ovf_clr,
  output logic              overflow,
  output logic              frame_err,
  output logic              busy
);

`ifdef LCD_SPI_9BIT_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam int              CNT_W       = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_W - 1);
  localparam bit              SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  // lcd_entry_t laid out at this instance's DATA_W.
  typedef struct packed {
    logic              dc;
    logic              first;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [2:0]        sclk_sync;
  logic [2:0]        ss_sync;
  logic [1:0]        mosi_sync;
  logic [1:0]        dc_sync;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              sample_edge;
  logic              ss_fall;
  logic              ss_rise;

  rx_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WORD_W-2:0] shift_reg, shift_next;
  logic              first_pend_reg, first_pend_next;
  logic              frame_err_next;
  logic              word_done;
  logic [WORD_W-1:0] word_value;
  entry_t            entry_next;
  entry_t            entry_reg;
  logic              push_reg;
  logic              frame_err_reg;
  logic              overflow_reg;

  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  // Pin synchronisers. Each resets to the idle bus level so that no edge
  // appears to occur as reset is released.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync <= {3{CPOL}};
      ss_sync   <= 3'b111;
      mosi_sync <= 2'b00;
      dc_sync   <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      ss_sync   <= {ss_sync[1:0], spi_ss_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      dc_sync   <= {dc_sync[0], spi_dc};
    end
  end

  assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign ss_fall     = ~ss_sync[1] & ss_sync[2];
  assign ss_rise     = ss_sync[1] & ~ss_sync[2];
  assign word_value  = {shift_reg, mosi_sync[1]};

  // Receiver state, bit counter and shift register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      first_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      first_pend_reg <= first_pend_next;
    end
  end

  // Framing and deserialisation. A deassert that arrives together with a
  // sample edge wins, and the edge is dropped. In IDLE every edge is ignored,
  // including one that coincides with the SS_n fall.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    first_pend_next = first_pend_reg;
    frame_err_next  = 1'b0;
    word_done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ss_fall) begin
          state_next      = ST_ACTIVE;
          bit_cnt_next    = '0;
          first_pend_next = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_next     = ST_IDLE;
          bit_cnt_next   = '0;
          frame_err_next = (bit_cnt_reg != '0);
        end else if (sample_edge) begin
          shift_next = word_value[WORD_W-2:0];
          if (bit_cnt_reg == LAST_BIT) begin
            word_done       = 1'b1;
            bit_cnt_next    = '0;
            first_pend_next = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Entry assembled from the completing bit. D/C comes either from the
  // leading bit of the word or from the synced D/C pin.
  always_comb begin
    entry_next.data  = word_value[DATA_W-1:0];
    entry_next.first = first_pend_reg;
`ifdef LCD_SPI_9BIT_EN
    entry_next.dc    = word_value[DATA_W];
`else
    entry_next.dc    = dc_sync[1];
`endif
  end

  // Staging register: a word completed in cycle N is written to the FIFO
  // in cycle N+1.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      push_reg      <= 1'b0;
      entry_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      push_reg      <= word_done;
      frame_err_reg <= frame_err_next;
      if (word_done) entry_reg <= entry_next;
    end
  end

  // A full FIFO is never empty, so an asserted rx_ready means a real pop
  // that frees a slot for the incoming word.
  assign drop = push_reg & fifo_full & ~rx_ready;

  // Sticky overflow flag. When a drop and ovf_clr coincide, the flag stays set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  lcd_rx_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (push_reg),
    .wdata (entry_reg),
    .pop   (rx_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_data   = head.data;
  assign rx_dc     = head.dc;
  assign rx_first  = head.first;
  assign rx_valid  = ~fifo_empty;
  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;
  assign busy      = ~ss_sync[1];

endmodule

// File: tb/tb_lcd_spi_target_rx.sv
// Bench for lcd_spi_target_rx: directed SPI frames, with a queue model of
// the expected words checked at every pop. When LCD_SPI_9BIT_EN is defined,
// the 9-bit 3-wire path is exercised.
`timescale 1ns/1ps
module tb_lcd_spi_target_rx;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0, dc = 1'b0;
  logic rx_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] rx_data;
  logic rx_dc, rx_first, rx_valid, overflow, frame_err, busy;

  lcd_spi_target_rx u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .spi_sclk(sclk), .spi_ss_n(ss_n), .spi_mosi(mosi), .spi_dc(dc),
    .rx_data(rx_data), .rx_dc(rx_dc), .rx_first(rx_first), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ovf_clr(ovf_clr), .overflow(overflow),
    .frame_err(frame_err), .busy(busy)
  );

  // Second bus: mode-3 stream into a CPOL=1/CPHA=1 target, and the same
  // stream with its clock inverted into a mode-0 target.
  logic sclk_b = 1'b1, ss_b = 1'b1, mosi_b = 1'b0, dc_b = 1'b1, b_ready = 1'b0, b_clr = 1'b0;
  logic sclk_b_inv;
  assign sclk_b_inv = ~sclk_b;
  logic [7:0] m3_data, m0_data;
  logic m3_dc, m3_first, m3_valid, m3_ovf, m3_fe, m3_busy;
  logic m0_dc, m0_first, m0_valid, m0_ovf, m0_fe, m0_busy;

  lcd_spi_target_rx #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .spi_sclk(sclk_b), .spi_ss_n(ss_b), .spi_mosi(mosi_b), .spi_dc(dc_b),
    .rx_data(m3_data), .rx_dc(m3_dc), .rx_first(m3_first), .rx_valid(m3_valid),
    .rx_ready(b_ready), .ovf_clr(b_clr), .overflow(m3_ovf),
    .frame_err(m3_fe), .busy(m3_busy)
  );

  lcd_spi_target_rx #(.CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .spi_sclk(sclk_b_inv), .spi_ss_n(ss_b), .spi_mosi(mosi_b), .spi_dc(dc_b),
    .rx_data(m0_data), .rx_dc(m0_dc), .rx_first(m0_first), .rx_valid(m0_valid),
    .rx_ready(b_ready), .ovf_clr(b_clr), .overflow(m0_ovf),
    .frame_err(m0_fe), .busy(m0_busy)
  );

  // ---------------- model and scoreboard ----------------
  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       first;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;
  int   total = 0;
  int   bad = 0;
  int   pops = 0;
  int   fe_cycles = 0;
  logic exp_ovf = 1'b0;
  logic frame_first = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic last_dc = 1'b0, last_first = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Compare process: each pop is checked against the queue front; during
  // reset, every output must read zero.
  always @(negedge clk) begin
    if (frame_err) fe_cycles++;
    if (!rst_n) begin
      check("reset_outputs", {18'b0, rx_valid, rx_data, rx_dc, rx_first, overflow, frame_err, busy}, 32'h0);
    end else if (rx_valid && rx_ready) begin
      check("word_expected", {31'b0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        check("pop_data", {24'b0, rx_data}, {24'b0, got.data});
        check("pop_dc", {31'b0, rx_dc}, {31'b0, got.dc});
        check("pop_first", {31'b0, rx_first}, {31'b0, got.first});
        pops++;
        last_data  = rx_data;
        last_dc    = rx_dc;
        last_first = rx_first;
        $display("pop %0d: data=%02h dc=%0b first=%0b", pops, rx_data, rx_dc, rx_first);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    frame_first = 1'b1;
    #100;
  endtask

  task automatic ss_high();
    #100 ss_n = 1'b1;
    #300;
  endtask

  // Raw mode-0 bits with no model update; used for partial words.
  task automatic send_bits(input logic [8:0] w, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      mosi = w[i];
      #100 sclk = 1'b1;
      #100 sclk = 1'b0;
    end
  endtask

  // One full mode-0 word. w[8] carries D/C in 9-bit mode; in 4-wire mode,
  // d drives spi_dc. The model is updated at the last sample edge.
  task automatic send_word(input logic [8:0] w, input logic d);
    int   nb;
    exp_t e;
    e.data  = w[7:0];
    e.first = frame_first;
`ifdef LCD_SPI_9BIT_EN
    nb   = 9;
    e.dc = w[8];
`else
    nb   = 8;
    e.dc = d;
    dc   = d;
`endif
    for (int i = nb - 1; i >= 0; i--) begin
      mosi = w[i];
`ifdef LCD_SPI_9BIT_EN
      dc = ~dc;
`endif
      #100 sclk = 1'b1;
      if (i == 0) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = 1'b1;
        frame_first = 1'b0;
      end
      #100 sclk = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(posedge clk);
    check("drain_in_time", exp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #55 rst_n = 1'b1;
    #100;

    // Reset/idle state and a basic command plus data frame.
    check("idle_valid", {31'b0, rx_valid}, 32'h0);
    check("idle_busy", {31'b0, busy}, 32'h0);
    set_ready(1'b1);
    ss_low();
    check("busy_active", {31'b0, busy}, 32'h1);
    send_word({1'b0, 8'h2C}, 1'b0);
    send_word({1'b1, 8'hA5}, 1'b1);
    send_word({1'b1, 8'h5A}, 1'b1);
    ss_high();
    wait_drain(200);
    check("t1_pops", pops, 3);
    check("t1_last_data", {24'b0, last_data}, 32'h5A);
    check("t1_last_dc", {31'b0, last_dc}, 32'h1);
    check("t1_last_first", {31'b0, last_first}, 32'h0);
    check("t1_no_frame_err", fe_cycles, 0);
    check("t1_empty", {31'b0, rx_valid}, 32'h0);

    // Overflow: 17 words into a 16-deep FIFO with no consumer.
    set_ready(1'b0);
    ss_low();
    for (int i = 0; i < 16; i++) send_word({1'b1, 8'(i)}, 1'b1);
    #200;
    check("t2_ovf_before", {31'b0, overflow}, {31'b0, exp_ovf});
    check("t2_valid_full", {31'b0, rx_valid}, 32'h1);
    send_word({1'b1, 8'h10}, 1'b1);
    ss_high();
    check("t2_ovf_after", {31'b0, overflow}, {31'b0, exp_ovf});
    check("t2_ovf_literal", {31'b0, overflow}, 32'h1);
    check("t2_head", {24'b0, rx_data}, 32'h00);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    #40;
    check("t2_ovf_cleared", {31'b0, overflow}, {31'b0, exp_ovf});
    base = pops;
    set_ready(1'b1);
    wait_drain(200);
    check("t2_drained", pops - base, 16);
    check("t2_last_data", {24'b0, last_data}, 32'h0F);

    // Partial word at deassert, then a clean frame.
    ss_low();
    send_bits(9'h1FF, 5);
    ss_high();
    check("t3_frame_err_cycles", fe_cycles, 1);
    check("t3_no_write", {31'b0, rx_valid}, 32'h0);
    ss_low();
    send_word({1'b1, 8'h81}, 1'b1);
    ss_high();
    wait_drain(200);
    check("t3_data", {24'b0, last_data}, 32'h81);
    check("t3_first", {31'b0, last_first}, 32'h1);
    check("t3_fe_unchanged", fe_cycles, 1);

`ifndef LCD_SPI_9BIT_EN
    // Mode 3 target versus a mode-0 target on the inverted clock.
    ss_b = 1'b0;
    #100;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] pat;
      pat = 8'h3C;
      sclk_b = 1'b0;
      #50 mosi_b = pat[i];
      #50 sclk_b = 1'b1;
      #100;
    end
    #100 ss_b = 1'b1;
    #300;
    check("m3_valid", {31'b0, m3_valid}, 32'h1);
    check("m3_data", {24'b0, m3_data}, 32'h3C);
    check("m3_dc", {31'b0, m3_dc}, 32'h1);
    check("m3_first", {31'b0, m3_first}, 32'h1);
    check("m0_not_3c", {31'b0, m0_data != 8'h3C}, 32'h1);
    check("m0_wrong_phase", {24'b0, m0_data}, 32'h1E);
`endif

    // Reset mid-word, then a fresh frame.
    ss_low();
    send_bits(9'h0C3, 4);
    rst_n = 1'b0;
    ss_n  = 1'b1;
    #5;
    check("t5_reset_zero", {18'b0, rx_valid, rx_data, rx_dc, rx_first, overflow, frame_err, busy}, 32'h0);
    #200;
    rst_n = 1'b1;
    #100;
    base = pops;
    ss_low();
    send_word({1'b1, 8'hC3}, 1'b1);
    ss_high();
    wait_drain(200);
    check("t5_single", pops - base, 1);
    check("t5_data", {24'b0, last_data}, 32'hC3);
    check("t5_first", {31'b0, last_first}, 32'h1);
    check("t5_no_frame_err", fe_cycles, 1);

`ifdef LCD_SPI_9BIT_EN
    // 9-bit words: the leading bit is D/C; spi_dc toggles throughout.
    ss_low();
    send_word(9'h169, 1'b0);
    wait_drain(200);
    check("t6_data_a", {24'b0, last_data}, 32'h69);
    check("t6_dc_a", {31'b0, last_dc}, 32'h1);
    send_word(9'h02A, 1'b1);
    ss_high();
    wait_drain(200);
    check("t6_data_b", {24'b0, last_data}, 32'h2A);
    check("t6_dc_b", {31'b0, last_dc}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_spi_target_rx.md
Name: lcd_spi_target_rx

Overview:
- SPI target (slave) receiver for the LCD command/data link.
- Used on the LCD-emulation side of the bridge, and as the checker endpoint in system benches.
- Oversamples SCLK/SS_n/MOSI/DC in the system clock domain, deserialises MSB-first words and tags each with its D/C bit and a first-of-frame flag.
- Buffers words in a small FIFO with a valid/ready stream toward a pixel/command consumer.

Parameters:
- DATA_W, 8, bits per SPI word (8..16).
- FIFO_DEPTH, 16, receive FIFO entries (power of 2, >=2).
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.

Ports:
- clk_clk  in  1  system clock; must be >= 4x SCLK frequency.
- reset_reset_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock from initiator.
- spi_ss_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data in.
- spi_dc  in  1  4-wire D/C line (1 = data, 0 = command).
- rx_data  out  DATA_W  head-of-FIFO word.
- rx_dc  out  1  D/C tag of rx_data.
- rx_first  out  1  rx_data is the first word after SS_n fell.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accept; pop when rx_valid & rx_ready.
- ovf_clr  in  1  clears the sticky overflow flag.
- overflow  out  1  sticky: a completed word was dropped.
- frame_err  out  1  1-cycle pulse: SS_n rose with a partial word.
- busy  out  1  synchronised SS_n is low.

Behaviour:
- Reset: rx_valid=0, rx_data=0, rx_dc=0, rx_first=0, overflow=0, frame_err=0, busy=0, FIFO empty, bit_cnt=0. Synchroniser flops reset to idle levels (sclk=CPOL, ss_n=1).
- Synchronisation: 2-flop synchroniser on each of sclk, ss_n, mosi and dc, plus a third sclk/ss_n stage for edge detection.
- Sample edge: for CPOL=0, CPHA=0, the sample edge is the synced rising edge of sclk. In general, the sample edge is the leading edge (transition away from the CPOL idle level) when CPHA=0, and the trailing edge when CPHA=1.
- States: IDLE (ss_n high), ACTIVE (ss_n low).
  - IDLE->ACTIVE on synced ss_n falling: bit_cnt=0, first_pend=1.
  - ACTIVE->IDLE on synced ss_n rising.
- Sample edges are ignored in IDLE.
- On each sample edge in ACTIVE: shift mosi into the shift register LSB, then bit_cnt++.
- When bit_cnt reaches DATA_W-1 and a sample edge occurs:
  - The word completes in that cycle (N).
  - The shift value, the synced dc and first_pend form the entry.
  - FIFO write happens at N+1; rx_valid is high by N+2 if the FIFO was empty.
  - bit_cnt wraps to 0 and first_pend clears.
- Pin-to-rx_valid latency: <= 5 clk_clk cycles after the raw SCLK sample edge.
- Full-FIFO write:
  - If a pop occurs in the same cycle, the write is accepted.
  - Otherwise the word is dropped and overflow is set.
- overflow persists until ovf_clr; if set and clear coincide, set wins.
- SS_n rising with bit_cnt != 0: discard the partial word and pulse frame_err for 1 cycle. With bit_cnt == 0 there is no pulse.
- SS_n rising in the same cycle as a sample edge: the edge is ignored and the deassert is processed.
- Sample edge and SS_n falling in the same cycle: the edge is ignored.
- FIFO: pointers of width log2(FIFO_DEPTH)+1, wrap-around by MSB compare. Pop on empty has no effect. rx_data/rx_dc/rx_first hold while rx_valid & !rx_ready.
- Async reset mid-frame: all state is cleared. The next word counts only after a fresh SS_n fall.

Optional Feature:
- Macro: LCD_SPI_9BIT_EN.
- Defined (3-wire 9-bit mode):
  - Each word is DATA_W+1 bits.
  - The first sampled bit is the D/C tag, followed by DATA_W data bits MSB-first.
  - spi_dc is ignored; bit_cnt counts to DATA_W.
  - A partial word at SS_n rise includes the case where only the D/C bit has been received.
- Undefined: 4-wire mode as above; D/C is the synced spi_dc at the completing edge.

Decomposition:
- Package lcd_spi_pkg: DATA_W default, FIFO_DEPTH default, CPOL/CPHA defaults, a FIFO entry struct {dc, first, data}, and a function computing the sample-edge select from CPOL/CPHA.
- Sub-module lcd_rx_fifo: synchronous FIFO with push/pop/full/empty, parameterised on entry width and depth.

Test Plan:
- Mode 0, 4-wire, clk_clk 50 MHz, SCLK 5 MHz: SS_n low, dc=0, send 0x2C; then dc=1, send 0xA5, 0x5A; SS_n high -> three pops {0x2C, dc0, first1}, {0xA5, dc1, first0}, {0x5A, dc1, first0}; frame_err never pulses.
- Hold rx_ready=0 and send 17 words 0x00..0x10 in one frame -> FIFO holds 0x00..0x0F; overflow=1 after the 17th word; ovf_clr pulse -> overflow=0; draining yields 16 words in order.
- SS_n rises after 5 bits of 0xFF -> frame_err high for exactly 1 cycle, no FIFO write; next frame byte 0x81 is received intact with first=1.
- CPOL=1, CPHA=1 instance, send 0x3C -> rx_data=0x3C; the same stream with the wrong edge phase on a CPOL=0/CPHA=0 instance does not produce 0x3C.
- Assert reset_reset_n=0 mid-word (4 bits in), release, send 0xC3 -> single word 0xC3 with first=1; all outputs 0 during reset.
- LCD_SPI_9BIT_EN: send 9-bit 1_0110_1001 -> rx_dc=1, rx_data=0x69; send 0_0010_1010 -> rx_dc=0, rx_data=0x2A; spi_dc toggling has no effect.
